uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  UART receive controller for the serial front end. Synchronises rx_i and detects the start-bit
//  falling edge, then steps a baud counter and bit FSM to centre-sample each bit.
//  Delivers each completed byte through a one-deep valid/ready holding register.
//  Reports framing, parity and overrun errors.
//  Sits between the pad input and the byte-level consumer (command parser / RX FIFO).
// PARAMETERS
//  CLKS_PER_BIT  434  clk_i cycles per bit (50 MHz / 115200); legal range >= 4
//  DATA_BITS     8    data bits per frame; legal range 5..8, sent LSB first
//  PARITY_EN     0    1 = one parity bit follows the data bits
//  PARITY_ODD    0    0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
// PORTS
//  clk_i         in   1          system clock
//  rst_n_i       in   1          asynchronous, active-low reset
//  rx_i          in   1          serial line, asynchronous to clk_i, idles high
//  rx_data_o     out  DATA_BITS  received byte; stable while rx_valid_o=1
//  rx_valid_o    out  1          byte available in the holding register
//  rx_ready_i    in   1          consumer accepts; transfer occurs when valid & ready
//  frame_err_o   out  1          1-cycle pulse: stop bit sampled low
//  parity_err_o  out  1          1-cycle pulse: parity mismatch
//  overrun_o     out  1          1-cycle pulse: byte lost because the holding register was full
//  busy_o        out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, sync flops reset to 1 (line idle).
//  Front end: 2-flop synchroniser, then a registered copy; fall = prev & ~cur. Edge latency 3 clk.
//  Baud counter: width $clog2(CLKS_PER_BIT); reloads on every state entry; wraps at CLKS_PER_BIT-1.
//  FSM:
//   IDLE   -> START on fall.
//   START  -> at count CLKS_PER_BIT/2-1, sample the line.
//             Line=1 (glitch/false start): return to IDLE, no flag.
//             Line=0: enter DATA.
//   DATA   -> sample every CLKS_PER_BIT cycles into a shift register (LSB first).
//             After DATA_BITS samples, enter PARITY if PARITY_EN, else STOP.
//   PARITY -> sample after CLKS_PER_BIT cycles; compare against XOR(data)^PARITY_ODD.
//   STOP   -> sample after CLKS_PER_BIT cycles.
//             The FSM returns to IDLE at the mid-stop sample, so a back-to-back start edge is caught.
//  Completion, in the cycle after the mid-stop sample:
//   - stop=0: frame_err_o pulses; byte discarded.
//   - stop=1, parity mismatch: parity_err_o pulses; byte discarded.
//   - good byte, rx_valid_o=0 or (rx_valid_o & rx_ready_i): load rx_data_o; rx_valid_o=1.
//   - good byte, rx_valid_o=1 & ~rx_ready_i: overrun_o pulses; new byte dropped, old byte kept.
//  Handshake: rx_valid_o stays high until the valid&ready cycle.
//   rx_valid_o clears on that cycle unless a load happens in the same cycle.
//  Break/line held low: only a stop=0 frame_err_o; no new start until the line has returned high.
//  Reset mid-frame: immediate abort to IDLE, holding register cleared, no error pulse.
// STRUCTURE
//  Shared package uart_pkg:
//   - FSM state encoding: IDLE, START, DATA, PARITY, STOP
//   - default CLKS_PER_BIT and DATA_BITS constants, shared with the future uart_tx_ctrl
//  Sub-module rx_sync_edge: synchroniser plus falling-edge detector, ports clk_i, rst_n_i, d_i,
//   sync_o, fall_o.
//  All other logic stays in this module.
// TESTING (bench CLKS_PER_BIT=16, DATA_BITS=8)
//  1. Frame 0x5A, 8N1, rx_ready_i=1:
//     -> rx_valid_o=1 for 1 cycle, rx_data_o=8'h5A, all error flags 0.
//  2. Line low for 5 clk only, then high:
//     -> false start; busy_o returns to 0, no rx_valid_o, no error flag.
//  3. Frame 0xA5 with stop bit=0:
//     -> frame_err_o pulse, rx_valid_o stays 0; the next good frame 0x3C is received.
//  4. PARITY_EN=1, PARITY_ODD=0, frame 0x07 sent with parity bit 0:
//     -> parity_err_o pulse, no rx_valid_o.
//  5. rx_ready_i=0; frames 0x11 then 0x22:
//     -> rx_data_o=8'h11 held, overrun_o pulse at the end of 0x22.
//     -> Then raise rx_ready_i: 0x11 transfers, rx_valid_o clears.
//  6. Assert rst_n_i mid-DATA of frame 0xFF:
//     -> outputs 0, FSM in IDLE; the following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default line-rate constants
// used by both the receive and (future) transmit controllers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned UART_CLKS_PER_BIT = 434;
  localparam int unsigned UART_DATA_BITS    = 8;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser for an asynchronous line, plus a registered falling-edge strobe.
// Flops reset to 1 so an idle-high line produces no edge on reset release.
module rx_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, fall_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fall_q <= prev_q & ~sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: centre-samples each frame and hands complete bytes to a one-deep
// valid/ready holding register, flagging framing, parity and overrun errors.
//   state  | meaning
//   IDLE   | waiting for a start-bit falling edge
//   START  | confirming the start bit at mid-bit
//   DATA   | shifting in data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | sampling the stop bit, result applied on the next cycle
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

  logic rx_sync, rx_fall;
  logic half_tick, bit_tick;
  logic data_smp, par_smp, stop_smp;
  logic par_bad, good, load;

  rx_sync_edge u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_i),
    .sync_o  (rx_sync),
    .fall_o  (rx_fall)
  );

  assign half_tick = (cnt_q == CNT_HALF);
  assign bit_tick  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (rx_fall) state_d = ST_START;
      ST_START:  if (half_tick) state_d = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_tick && (bit_q == BIT_LAST)) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
      ST_STOP:   if (bit_tick) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != ST_IDLE);
    data_smp = (state_q == ST_DATA)   && bit_tick;
    par_smp  = (state_q == ST_PARITY) && bit_tick;
    stop_smp = (state_q == ST_STOP)   && bit_tick;
  end

  // Baud counter restarts on every state change so each state times from its own entry.
  always_comb begin
    if ((state_d != state_q) || (state_q == ST_IDLE) || bit_tick) cnt_d = '0;
    else                                                          cnt_d = cnt_q + CNT_W'(1);
    if (state_q != ST_DATA) bit_d = '0;
    else if (data_smp)      bit_d = bit_q + BIT_W'(1);
    else                    bit_d = bit_q;
    shift_d   = data_smp ? {rx_sync, shift_q[DATA_BITS-1:1]} : shift_q;
    par_bit_d = par_smp ? rx_sync : par_bit_q;
  end

  always_comb begin
    par_bad = PARITY_EN && (par_bit_q != ((^shift_q) ^ PARITY_ODD));
    good    = stop_smp & rx_sync & ~par_bad;
    load    = good & (~valid_q | rx_ready_i);
    ferr_d  = stop_smp & ~rx_sync;
    perr_d  = stop_smp & rx_sync & par_bad;
    ovr_d   = good & valid_q & ~rx_ready_i;
    valid_d = load | (valid_q & ~rx_ready_i);
    data_d  = load ? shift_q : data_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = perr_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: an 8N1 instance and an 8E1 instance, each with
// its own expected-event queue drained by a negedge monitor.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1, rx_p = 1'b1;
  logic       ready_a = 1'b1, ready_p = 1'b1;
  logic [7:0] a_data, p_data;
  logic       a_valid, a_ferr, a_perr, a_ovr, a_busy;
  logic       p_valid, p_ferr, p_perr, p_ovr, p_busy;

  always #5 clk_i = ~clk_i;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n), .rx_i(rx_a), .rx_data_o(a_data), .rx_valid_o(a_valid),
    .rx_ready_i(ready_a), .frame_err_o(a_ferr), .parity_err_o(a_perr), .overrun_o(a_ovr),
    .busy_o(a_busy)
  );

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_par (
    .clk_i(clk_i), .rst_n_i(rst_n), .rx_i(rx_p), .rx_data_o(p_data), .rx_valid_o(p_valid),
    .rx_ready_i(ready_p), .frame_err_o(p_ferr), .parity_err_o(p_perr), .overrun_o(p_ovr),
    .busy_o(p_busy)
  );

  typedef enum logic [1:0] {EV_DATA, EV_FERR, EV_PERR, EV_OVR} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_a[$];
  ev_t exp_p[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  valid_cycles = 0;
  bit  saw_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input bit is_p, input ev_kind_e kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    if (is_p) exp_p.push_back(e);
    else      exp_a.push_back(e);
  endtask

  task automatic mon_event(input bit is_p, input ev_kind_e kind, input logic [7:0] data);
    ev_t   e;
    string pfx;
    pfx = is_p ? "par" : "8n1";
    if ((is_p && exp_p.size() == 0) || (!is_p && exp_a.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_unexpected_event: got kind %0d data %0h, expected no event", pfx, kind, data);
    end else begin
      e = is_p ? exp_p.pop_front() : exp_a.pop_front();
      check({pfx, "_event_kind"}, 32'(kind), 32'(e.kind));
      if (kind == EV_DATA && e.kind == EV_DATA) check({pfx, "_event_data"}, 32'(data), 32'(e.data));
    end
  endtask

  always @(negedge clk_i) begin
    if (a_ferr) mon_event(1'b0, EV_FERR, 8'h00);
    if (a_perr) mon_event(1'b0, EV_PERR, 8'h00);
    if (a_ovr)  mon_event(1'b0, EV_OVR, 8'h00);
    if (a_valid && ready_a) mon_event(1'b0, EV_DATA, a_data);
    if (p_ferr) mon_event(1'b1, EV_FERR, 8'h00);
    if (p_perr) mon_event(1'b1, EV_PERR, 8'h00);
    if (p_ovr)  mon_event(1'b1, EV_OVR, 8'h00);
    if (p_valid && ready_p) mon_event(1'b1, EV_DATA, p_data);
    if (a_valid) valid_cycles++;
    if (a_busy)  saw_busy = 1'b1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_line(input bit is_p, input logic v);
    if (is_p) rx_p = v;
    else      rx_a = v;
  endtask

  task automatic send_frame(input bit is_p, input logic [7:0] b, input logic stop_bit,
                            input bit with_par, input logic par_bit);
    set_line(is_p, 1'b0);
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      set_line(is_p, b[i]);
      wait_clks(CPB);
    end
    if (with_par) begin
      set_line(is_p, par_bit);
      wait_clks(CPB);
    end
    set_line(is_p, stop_bit);
    wait_clks(CPB);
    set_line(is_p, 1'b1);
    wait_clks(CPB);
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_a.size() + exp_p.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    wait_clks(3);
    check("reset_outputs", {19'd0, a_valid, a_data, a_ferr, a_perr, a_ovr, a_busy}, 32'd0);
    rst_n = 1'b1;
    wait_clks(4);

    valid_cycles = 0;
    push_exp(1'b0, EV_DATA, 8'h5A);
    send_frame(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
    check_drained("t1_drained");
    check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
    check("t1_valid_after", 32'(a_valid), 32'd0);

    saw_busy = 1'b0;
    rx_a = 1'b0;
    wait_clks(5);
    rx_a = 1'b1;
    wait_clks(3 * CPB);
    check("t2_saw_busy", 32'(saw_busy), 32'd1);
    check("t2_busy_idle", 32'(a_busy), 32'd0);
    check_drained("t2_drained");

    push_exp(1'b0, EV_FERR, 8'h00);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_drained("t3_ferr_drained");
    push_exp(1'b0, EV_DATA, 8'h3C);
    send_frame(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
    check_drained("t3_good_drained");

    push_exp(1'b1, EV_PERR, 8'h00);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
    check_drained("t4_perr_drained");
    push_exp(1'b1, EV_DATA, 8'h07);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    check_drained("t4_good_drained");

    ready_a = 1'b0;
    send_frame(1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
    check("t5_valid_held", 32'(a_valid), 32'd1);
    check("t5_data_first", 32'(a_data), 32'h11);
    push_exp(1'b0, EV_OVR, 8'h00);
    send_frame(1'b0, 8'h22, 1'b1, 1'b0, 1'b0);
    check_drained("t5_ovr_drained");
    check("t5_data_kept", 32'(a_data), 32'h11);
    check("t5_valid_kept", 32'(a_valid), 32'd1);
    push_exp(1'b0, EV_DATA, 8'h11);
    ready_a = 1'b1;
    wait_clks(2);
    check_drained("t5_xfer_drained");
    check("t5_valid_cleared", 32'(a_valid), 32'd0);

    ready_a = 1'b0;
    send_frame(1'b0, 8'h42, 1'b1, 1'b0, 1'b0);
    rx_a = 1'b0;
    wait_clks(CPB);
    rx_a = 1'b1;
    wait_clks(3 * CPB);
    check("t6_busy_mid_frame", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    wait_clks(2);
    check("t6_reset_outputs", {19'd0, a_valid, a_data, a_ferr, a_perr, a_ovr, a_busy}, 32'd0);
    rst_n = 1'b1;
    ready_a = 1'b1;
    wait_clks(4 * CPB);
    check("t6_idle_after_reset", 32'(a_busy), 32'd0);
    push_exp(1'b0, EV_DATA, 8'h81);
    send_frame(1'b0, 8'h81, 1'b1, 1'b0, 1'b0);
    check_drained("t6_drained");

    wait_clks(10);
    check_drained("final_drained");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
